tdm_demux: RTL and testbench
============================

# tdm_demux

Time-division demultiplexer: receives a framed, beat-serial stream in which each valid beat carries one channel's word, and steers every beat into its own per-channel output register. It is the receive end for the mux-based channel serializer used in the combinational-logic exercises. A frame marker aligns the channel counter, and per-channel strobes flag each update. Malformed frames are reported and resynchronised.

## Interface
- N_CH, 4: number of channels per frame, ≥ 2.
- W, 8: word width in bits.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  beat qualifier; the beat is consumed when high.
- in_sof  in  1  start of frame; meaningful only when in_valid is high.
- in_data  in  W  beat payload.
- out_data  out  N_CH*W  packed channel registers; channel k occupies bits [k*W +: W].
- out_valid  out  N_CH  one-cycle pulse, bit k = channel k register updated.
- frame_done  out  1  one-cycle pulse; the last channel of a complete frame was written.
- frame_err  out  1  one-cycle pulse; the frame was truncated by an early in_sof.

## Operation
- States: IDLE (unsynchronised) and RUN (inside a frame). The channel counter `ch` is clog2(N_CH) bits wide.
- Beat acceptance: a beat is any cycle with in_valid=1. The input is never back-pressured. Beats with in_valid=0 are ignored, including their in_sof and in_data.
- IDLE:
  - Beat with in_sof=0: dropped. No output changes.
  - Beat with in_sof=1: write to channel 0, pulse out_valid[0], set ch=1, go to RUN.
- RUN:
  - Beat with in_sof=0: write to channel ch and pulse out_valid[ch].
    - If ch==N_CH-1: also pulse frame_done, set ch=0, go to IDLE.
    - Otherwise: increment ch.
  - Beat with in_sof=1 (early start of frame): pulse frame_err. The beat is treated as channel 0 of a new frame: write channel 0, pulse out_valid[0], set ch=1, stay in RUN.
  - Channel registers written earlier in the aborted frame keep their values.
- Channel registers hold their value until they are overwritten. Only the addressed channel changes on a beat.
- frame_done and frame_err are mutually exclusive. frame_err never fires in IDLE.
- No modular wrap of ch: completing a frame always returns to IDLE, so the next frame requires in_sof.

## Timing
- All outputs are registered. Latency is 1 cycle: a beat accepted at edge n appears on out_data, with its strobes, after edge n.
- out_valid, frame_done and frame_err are high for exactly one cycle per qualifying beat. Back-to-back beats give back-to-back pulses.
- Gaps (in_valid=0) may occur anywhere inside a frame. The state and ch are held across gaps.
- Reset values (applied asynchronously, released synchronously by design convention):
  - state=IDLE, ch=0.
  - out_data all zeros, out_valid=0, frame_done=0, frame_err=0.
- Reset asserted mid-frame aborts the frame silently: no frame_err and no frame_done.
- in_sof=1 together with in_valid=1 in the same cycle as the last channel position is treated as an early start of frame: frame_err fires, not frame_done.

## Structure
- Shared package tdm_pkg:
  - typedef for the state enum {IDLE, RUN}.
  - default constants TDM_N_CH=4 and TDM_W=8, which the parameters reference.
- One sub-module, tdm_channel_counter: holds ch and the state. It takes beat and sof, and produces ch, in_frame, last, and an err strobe.
- The top level holds the channel register array and the strobe registers.

## Test plan
All scenarios use N_CH=4, W=8.

1. Reset release, then no beats → out_data=0x00000000, all strobes stay 0.
2. Beats (sof,data) = (1,A1),(0,B2),(0,C3),(0,D4) on consecutive cycles:
   - out_valid = 0001, 0010, 0100, 1000 on successive cycles, one cycle after each beat.
   - frame_done pulses with out_valid[3].
   - Final out_data=0xD4C3B2A1.
3. Beats without sof while in IDLE (data 0x55, twice), then a full frame 11,22,33,44:
   - The 0x55 beats produce no strobes.
   - Final out_data=0x44332211.
4. Frame 01,02, then a sof beat 0xAA, then 0xBB,0xCC,0xDD:
   - frame_err pulses exactly once, on the AA beat.
   - frame_done pulses on the DD beat.
   - Final out_data=0xDDCCBBAA.
5. Frame 10,20 with 3 idle cycles between each beat (gaps), then 30,40:
   - Strobes occur only on beats.
   - frame_done pulses once, after the 40 beat.
6. Assert rst after 2 beats of a frame, release, then send beats 0x77,0x88 without sof:
   - No strobes.
   - out_data=0 and state=IDLE immediately on assertion.
   - No frame_err.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared types and defaults for the TDM demultiplexer slice.
package tdm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tdm_state_e;

    localparam int unsigned TDM_N_CH = 4;
    localparam int unsigned TDM_W    = 8;

    // Width of a channel index; a single-channel build would still need one bit.
    function automatic int unsigned tdm_cw(input int unsigned n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/tdm_channel_counter.sv
// Frame tracker: holds the IDLE/RUN state and the next channel position.
module tdm_channel_counter
    import tdm_pkg::*;
#(
    parameter int unsigned N_CH = TDM_N_CH,
    parameter int unsigned CW   = tdm_cw(N_CH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          beat,
    input  logic          sof,
    output logic [CW-1:0] ch,
    output logic          in_frame,
    output logic          last,
    output logic          err
);

    tdm_state_e    state;
    logic [CW-1:0] ch_q;

    assign ch       = ch_q;
    assign in_frame = (state == RUN);
    assign last     = in_frame && (ch_q == CW'(N_CH - 1));
    // An sof arriving inside a frame truncates it, even at the last position.
    assign err      = beat && sof && in_frame;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ch_q  <= '0;
        end else if (beat) begin
            if (sof) begin
                state <= RUN;
                ch_q  <= CW'(1);
            end else if (state == RUN) begin
                if (ch_q == CW'(N_CH - 1)) begin
                    state <= IDLE;
                    ch_q  <= '0;
                end else begin
                    ch_q <= ch_q + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: steers each framed beat into its channel register.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int unsigned N_CH = TDM_N_CH,
    parameter int unsigned W    = TDM_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [W-1:0]      in_data,
    output logic [N_CH*W-1:0] out_data,
    output logic [N_CH-1:0]   out_valid,
    output logic              frame_done,
    output logic              frame_err
);

    localparam int unsigned CW = tdm_cw(N_CH);

    logic [CW-1:0]   ch;
    logic            in_frame;
    logic            last;
    logic            err;
    logic            wr_en;
    logic [CW-1:0]   wr_ch;
    logic [N_CH-1:0] wr_sel;

    tdm_channel_counter #(
        .N_CH (N_CH),
        .CW   (CW)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .beat     (in_valid),
        .sof      (in_sof),
        .ch       (ch),
        .in_frame (in_frame),
        .last     (last),
        .err      (err)
    );

    // Beats outside a frame are dropped unless they open one; sof always lands on channel 0.
    always_comb begin
        wr_en  = in_valid && (in_sof || in_frame);
        wr_ch  = in_sof ? '0 : ch;
        wr_sel = '0;
        if (wr_en) begin
            wr_sel[wr_ch] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data   <= '0;
            out_valid  <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            out_valid  <= wr_sel;
            frame_done <= in_valid && !in_sof && last;
            frame_err  <= err;
            for (int unsigned k = 0; k < N_CH; k++) begin
                if (wr_sel[k]) begin
                    out_data[k*W +: W] <= in_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux with N_CH=4, W=8.
module tb_tdm_demux;

    localparam int unsigned N_CH = 4;
    localparam int unsigned W    = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_sof = 1'b0;
    logic [W-1:0]      in_data = '0;
    logic [N_CH*W-1:0] out_data;
    logic [N_CH-1:0]   out_valid;
    logic              frame_done;
    logic              frame_err;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  vld;
        logic        done;
        logic        err;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_data[4];
    bit         m_run;
    int         m_ch;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         err_seen  = 0;
    int         done_seen = 0;
    int         vld_seen  = 0;

    tdm_demux #(
        .N_CH (N_CH),
        .W    (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_data    (in_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_word();
        return {m_data[3], m_data[2], m_data[1], m_data[0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_data[i] = 8'h00;
        m_run = 1'b0;
        m_ch  = 0;
    endtask

    // Drive one cycle, predict the registered result, then compare after the edge.
    task automatic step(input string tag, input bit v, input bit sof, input logic [7:0] d);
        exp_t e;
        exp_t o;
        @(negedge clk);
        in_valid = v;
        in_sof   = sof;
        in_data  = d;
        e.vld  = '0;
        e.done = 1'b0;
        e.err  = 1'b0;
        if (v) begin
            if (sof) begin
                e.err     = m_run;
                m_data[0] = d;
                e.vld     = 4'b0001;
                m_run     = 1'b1;
                m_ch      = 1;
            end else if (m_run) begin
                m_data[m_ch] = d;
                e.vld        = 4'(1 << m_ch);
                if (m_ch == 3) begin
                    e.done = 1'b1;
                    m_run  = 1'b0;
                    m_ch   = 0;
                end else begin
                    m_ch++;
                end
            end
        end
        e.data = m_word();
        sb.push_back(e);
        @(posedge clk);
        #1;
        o = sb.pop_front();
        check({tag, "_data"}, 64'(out_data), 64'(o.data));
        check({tag, "_vld"},  64'(out_valid), 64'(o.vld));
        check({tag, "_done"}, 64'(frame_done), 64'(o.done));
        check({tag, "_err"},  64'(frame_err), 64'(o.err));
        if (frame_err)  err_seen++;
        if (frame_done) done_seen++;
        if (out_valid != '0) vld_seen++;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_data", 64'(out_data), 64'h0);
        check("rst_strb", 64'({out_valid, frame_done, frame_err}), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // 1: idle cycles, with noise on sof/data that must be ignored
        vld_seen = 0;
        for (int i = 0; i < 4; i++) step("t1", 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
        check("t1_nostrobe", 64'(vld_seen), 64'd0);

        // 2: clean frame
        done_seen = 0;
        step("t2a", 1'b1, 1'b1, 8'hA1);
        step("t2b", 1'b1, 1'b0, 8'hB2);
        step("t2c", 1'b1, 1'b0, 8'hC3);
        step("t2d", 1'b1, 1'b0, 8'hD4);
        check("t2_final", 64'(out_data), 64'hD4C3B2A1);
        check("t2_done_cnt", 64'(done_seen), 64'd1);

        // 3: beats without sof in IDLE are dropped
        vld_seen = 0;
        step("t3x", 1'b1, 1'b0, 8'h55);
        step("t3y", 1'b1, 1'b0, 8'h55);
        check("t3_drop", 64'(vld_seen), 64'd0);
        step("t3a", 1'b1, 1'b1, 8'h11);
        step("t3b", 1'b1, 1'b0, 8'h22);
        step("t3c", 1'b1, 1'b0, 8'h33);
        step("t3d", 1'b1, 1'b0, 8'h44);
        check("t3_final", 64'(out_data), 64'h44332211);

        // 4: early sof truncates a frame
        err_seen = 0;
        done_seen = 0;
        step("t4a", 1'b1, 1'b1, 8'h01);
        step("t4b", 1'b1, 1'b0, 8'h02);
        step("t4s", 1'b1, 1'b1, 8'hAA);
        step("t4c", 1'b1, 1'b0, 8'hBB);
        step("t4d", 1'b1, 1'b0, 8'hCC);
        step("t4e", 1'b1, 1'b0, 8'hDD);
        check("t4_final", 64'(out_data), 64'hDDCCBBAA);
        check("t4_err_cnt", 64'(err_seen), 64'd1);
        check("t4_done_cnt", 64'(done_seen), 64'd1);

        // 4b: sof at the last channel position is an error, not a completion
        err_seen = 0;
        done_seen = 0;
        step("t4f", 1'b1, 1'b1, 8'h91);
        step("t4g", 1'b1, 1'b0, 8'h92);
        step("t4h", 1'b1, 1'b0, 8'h93);
        step("t4i", 1'b1, 1'b1, 8'h94);
        check("t4b_err_cnt", 64'(err_seen), 64'd1);
        check("t4b_done_cnt", 64'(done_seen), 64'd0);
        step("t4j", 1'b1, 1'b0, 8'h95);
        step("t4k", 1'b1, 1'b0, 8'h96);
        step("t4l", 1'b1, 1'b0, 8'h97);
        check("t4b_final", 64'(out_data), 64'h97969594);

        // 5: gaps inside a frame hold state
        vld_seen = 0;
        done_seen = 0;
        step("t5a", 1'b1, 1'b1, 8'h10);
        for (int i = 0; i < 3; i++) step("t5g", 1'b0, 1'b0, 8'hEE);
        step("t5b", 1'b1, 1'b0, 8'h20);
        for (int i = 0; i < 3; i++) step("t5h", 1'b0, 1'b1, 8'hEE);
        step("t5c", 1'b1, 1'b0, 8'h30);
        step("t5d", 1'b1, 1'b0, 8'h40);
        check("t5_strobes", 64'(vld_seen), 64'd4);
        check("t5_done_cnt", 64'(done_seen), 64'd1);
        check("t5_final", 64'(out_data), 64'h40302010);

        // 6: reset mid-frame aborts silently
        err_seen = 0;
        vld_seen = 0;
        step("t6a", 1'b1, 1'b1, 8'h61);
        step("t6b", 1'b1, 1'b0, 8'h62);
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check("t6_rst_data", 64'(out_data), 64'h0);
        check("t6_rst_idle", 64'(dut.in_frame), 64'h0);
        check("t6_rst_strb", 64'({out_valid, frame_done, frame_err}), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        vld_seen = 0;
        step("t6c", 1'b1, 1'b0, 8'h77);
        step("t6d", 1'b1, 1'b0, 8'h88);
        check("t6_nostrobe", 64'(vld_seen), 64'd0);
        check("t6_noerr", 64'(err_seen), 64'd0);
        check("t6_final", 64'(out_data), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
